// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a Wishbone
// classic master port. Uncached region selected by the top address nibble.
module dcache_wt #(
    parameter int          NUM_LINES    = 16,
    parameter int          LINE_WORDS   = 4,
    parameter logic [3:0]  UNCACHED_TOP = 4'hA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_req_addr_i,
    input  logic [31:0] mem_req_wdata_i,
    input  logic        mem_req_we_i,
    input  logic [3:0]  mem_req_be_i,
    input  logic        mem_req_valid_i,
    input  logic        flush_i,
    output logic [31:0] mem_resp_data_o,
    output logic        mem_req_ready_o,
    output logic        mem_resp_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_rty_i,
    input  logic        wb_err_i
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 30 - OW - IW;
    localparam int BW = (OW == 0) ? 1 : OW;
    localparam int AW = IW + OW;

    typedef enum logic [2:0] {IDLE, REFILL, WRITE, UNC_RD, DONE} state_t;

    state_t               state;
    logic [NUM_LINES-1:0] valid_q;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES*LINE_WORDS];
    logic [BW-1:0]        beat;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [BW-1:0] req_word;
    logic [AW-1:0] hit_ptr, beat_ptr;
    logic [31:0]   line_base;
    logic          uncached, hit, bus_ok, last_beat;
    logic          unused_ok;

    assign req_tag   = mem_req_addr_i[31 -: TW];
    assign req_idx   = mem_req_addr_i[2+OW +: IW];
    assign req_word  = (OW == 0) ? '0 : mem_req_addr_i[2 +: BW];
    assign hit_ptr   = AW'(int'(req_idx) * LINE_WORDS + int'(req_word));
    assign beat_ptr  = AW'(int'(req_idx) * LINE_WORDS + int'(beat));
    assign line_base = {mem_req_addr_i[31:2+OW], {(OW+2){1'b0}}};
    assign uncached  = (mem_req_addr_i[31:28] == UNCACHED_TOP);
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // a beat completes only on a plain ack; err and rty take precedence
    assign bus_ok    = wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i;
    assign last_beat = (beat == BW'(LINE_WORDS - 1));
    assign unused_ok = &{1'b0, mem_req_addr_i[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            valid_q         <= '0;
            beat            <= '0;
            mem_resp_data_o <= '0;
            mem_req_ready_o <= 1'b0;
            mem_resp_err_o  <= 1'b0;
            wb_adr_o        <= '0;
            wb_dat_o        <= '0;
            wb_we_o         <= 1'b0;
            wb_sel_o        <= '0;
            wb_stb_o        <= 1'b0;
            wb_cyc_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_req_ready_o <= 1'b0;
                    mem_resp_err_o  <= 1'b0;
                    if (flush_i) begin
                        valid_q <= '0;
                    end else if (mem_req_valid_i) begin
                        if (mem_req_we_i) begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b1;
                            wb_adr_o <= mem_req_addr_i;
                            wb_dat_o <= mem_req_wdata_i;
                            wb_sel_o <= mem_req_be_i;
                            state    <= WRITE;
                        end else if (uncached) begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b0;
                            wb_adr_o <= mem_req_addr_i;
                            wb_sel_o <= mem_req_be_i;
                            state    <= UNC_RD;
                        end else if (hit) begin
                            mem_resp_data_o <= data_q[hit_ptr];
                            mem_req_ready_o <= 1'b1;
                            state           <= DONE;
                        end else begin
                            valid_q[req_idx] <= 1'b0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b0;
                            wb_sel_o <= 4'hF;
                            wb_adr_o <= line_base;
                            beat     <= '0;
                            state    <= REFILL;
                        end
                    end
                end
                REFILL, WRITE, UNC_RD: begin
                    if (!wb_stb_o) begin
                        // strobe was dropped after a retry: reissue the same beat
                        wb_stb_o <= 1'b1;
                    end else if (wb_err_i) begin
                        wb_cyc_o        <= 1'b0;
                        wb_stb_o        <= 1'b0;
                        wb_we_o         <= 1'b0;
                        mem_resp_err_o  <= 1'b1;
                        mem_resp_data_o <= '0;
                        mem_req_ready_o <= 1'b1;
                        beat            <= '0;
                        state           <= DONE;
                    end else if (wb_rty_i) begin
                        wb_stb_o <= 1'b0;
                    end else if (wb_ack_i) begin
                        if (state == REFILL) begin
                            if (beat == req_word)
                                mem_resp_data_o <= wb_dat_i;
                            if (last_beat) begin
                                valid_q[req_idx] <= 1'b1;
                                wb_cyc_o         <= 1'b0;
                                wb_stb_o         <= 1'b0;
                                mem_req_ready_o  <= 1'b1;
                                beat             <= '0;
                                state            <= DONE;
                            end else begin
                                beat     <= beat + 1'b1;
                                wb_adr_o <= line_base | (32'(beat + 1'b1) << 2);
                            end
                        end else begin
                            mem_resp_data_o <= (state == UNC_RD) ? wb_dat_i : 32'h0;
                            wb_cyc_o        <= 1'b0;
                            wb_stb_o        <= 1'b0;
                            wb_we_o         <= 1'b0;
                            mem_req_ready_o <= 1'b1;
                            state           <= DONE;
                        end
                    end
                end
                DONE: begin
                    mem_req_ready_o <= 1'b0;
                    mem_resp_err_o  <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Arrays carry no reset; validity is tracked solely by valid_q.
    always_ff @(posedge clk) begin
        if (state == REFILL && bus_ok) begin
            data_q[beat_ptr] <= wb_dat_i;
            if (last_beat)
                tag_q[req_idx] <= req_tag;
        end
        if (state == WRITE && bus_ok && !uncached && hit) begin
            for (int b = 0; b < 4; b++)
                if (mem_req_be_i[b])
                    data_q[hit_ptr][8*b +: 8] <= mem_req_wdata_i[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: a line-level cache model plus a memory image
// predicts every response and every Wishbone beat the DUT should issue.
module tb_dcache_wt;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_req_addr_i = '0, mem_req_wdata_i = '0;
    logic        mem_req_we_i = 1'b0, mem_req_valid_i = 1'b0, flush_i = 1'b0;
    logic [3:0]  mem_req_be_i = '0;
    logic [31:0] mem_resp_data_o, wb_adr_o, wb_dat_o;
    logic        mem_req_ready_o, mem_resp_err_o, wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_rty_i = 1'b0, wb_err_i = 1'b0;

    dcache_wt #(.NUM_LINES(16), .LINE_WORDS(4), .UNCACHED_TOP(4'hA)) dut (
        .clk(clk), .rst(rst),
        .mem_req_addr_i(mem_req_addr_i), .mem_req_wdata_i(mem_req_wdata_i),
        .mem_req_we_i(mem_req_we_i), .mem_req_be_i(mem_req_be_i),
        .mem_req_valid_i(mem_req_valid_i), .flush_i(flush_i),
        .mem_resp_data_o(mem_resp_data_o), .mem_req_ready_o(mem_req_ready_o),
        .mem_resp_err_o(mem_resp_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_rty_i(wb_rty_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          kind;   // 0 ack, 1 rty, 2 err
    } bus_t;

    int tests = 0, fails = 0;
    bus_t act_log[$], exp_log[$];
    logic [31:0] smem [logic [31:0]];
    logic [31:0] mref [logic [31:0]];
    bit          mvalid [16];
    logic [23:0] mtag [16];
    int          scnt = 0, rty_at = -1, err_at = -1;
    logic [31:0] exp_data, last_data;
    logic        exp_err, exp_load, exp_hit, last_err;

    function automatic logic [31:0] def_w(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A00, ~a[15:0]};
    endfunction
    function automatic logic [31:0] srd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : def_w(a);
    endfunction
    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mref.exists(a) ? mref[a] : def_w(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Wishbone slave: strobe index scnt selects injected retry/error.
    always @(negedge clk) begin
        bus_t e;
        if (wb_cyc_o && wb_stb_o) begin
            e.adr = wb_adr_o; e.we = wb_we_o; e.sel = wb_sel_o; e.dat = wb_dat_o;
            e.kind = (scnt == err_at) ? 2 : (scnt == rty_at) ? 1 : 0;
            scnt++;
            act_log.push_back(e);
            wb_ack_i = (e.kind == 0); wb_rty_i = (e.kind == 1); wb_err_i = (e.kind == 2);
            wb_dat_i = (e.kind == 0 && !e.we) ? srd(e.adr) : 32'h0;
            if (e.kind == 0 && e.we) begin
                logic [31:0] w;
                w = srd(e.adr);
                for (int b = 0; b < 4; b++) if (e.sel[b]) w[8*b +: 8] = e.dat[8*b +: 8];
                smem[e.adr] = w;
            end
        end else begin
            wb_ack_i = 1'b0; wb_rty_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
        end
    end

    // Response checker: every ready pulse must match the model.
    always @(negedge clk) begin
        if (!rst && mem_req_ready_o) begin
            chk("resp_err", 64'(mem_resp_err_o), 64'(exp_err));
            if (exp_load) chk("resp_data", 64'(mem_resp_data_o), 64'(exp_data));
            chk("done_bus_idle", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    endtask

    task automatic predict(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic fl);
        bus_t nom[$];
        bus_t e, r;
        int s;
        bit unc, hit;
        int idx;
        exp_log.delete();
        if (fl) model_reset();
        unc = (a[31:28] == 4'hA);
        idx = int'(a[7:4]);
        hit = !unc && mvalid[idx] && (mtag[idx] == a[31:8]);
        exp_hit = !we && hit;
        e.we = we; e.sel = be; e.dat = we ? wd : 32'h0; e.kind = 0; e.adr = a;
        if (we || unc) nom.push_back(e);
        else if (!hit)
            for (int b = 0; b < 4; b++) begin
                e.adr = {a[31:4], 4'h0} + 32'(4 * b); e.sel = 4'hF;
                nom.push_back(e);
            end
        exp_err = 1'b0; s = 0;
        foreach (nom[k]) begin
            if (!exp_err) begin
                e = nom[k];
                if (s == err_at) begin
                    e.kind = 2; exp_log.push_back(e); exp_err = 1'b1;
                end else begin
                    if (s == rty_at) begin r = e; r.kind = 1; exp_log.push_back(r); s++; end
                    exp_log.push_back(e); s++;
                end
            end
        end
        if (!we && !unc && !hit) begin
            mvalid[idx] = !exp_err;
            mtag[idx] = a[31:8];
        end
        if (we && !exp_err) begin
            logic [31:0] w;
            w = mrd(a);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            mref[a] = w;
        end
        exp_load = !we;
        exp_data = exp_err ? 32'h0 : mrd(a);
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic fl);
        int lat;
        bit faulty;
        faulty = (rty_at >= 0) || (err_at >= 0);
        predict(we, a, wd, be, fl);
        act_log.delete(); scnt = 0;
        mem_req_we_i = we; mem_req_addr_i = a; mem_req_wdata_i = wd; mem_req_be_i = be;
        mem_req_valid_i = 1'b1; flush_i = fl;
        lat = 0;
        do begin
            @(negedge clk); lat++; flush_i = 1'b0;
        end while (!mem_req_ready_o && lat < 60);
        if (!mem_req_ready_o) chk("ready_timeout", 64'(lat), 64'(0));
        last_data = mem_resp_data_o; last_err = mem_resp_err_o;
        if (exp_hit) chk("hit_latency", 64'(lat), 64'(1));
        else if (!faulty) chk("latency_bound", 64'(lat <= (fl ? 7 : 6)), 64'(1));
        mem_req_valid_i = 1'b0;
        @(negedge clk);
        chk("ready_one_cycle", 64'(mem_req_ready_o), 64'(0));
        chk("bus_len", 64'(act_log.size()), 64'(exp_log.size()));
        foreach (exp_log[k]) if (k < act_log.size()) begin
            chk("bus_adr", 64'(act_log[k].adr), 64'(exp_log[k].adr));
            chk("bus_we_sel_kind", {act_log[k].we, act_log[k].sel, 32'(act_log[k].kind)},
                {exp_log[k].we, exp_log[k].sel, 32'(exp_log[k].kind)});
            if (exp_log[k].we) chk("bus_dat", 64'(act_log[k].dat), 64'(exp_log[k].dat));
        end
        rty_at = -1; err_at = -1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk("rst_ctrl", 64'({mem_req_ready_o, mem_resp_err_o, wb_cyc_o, wb_stb_o, wb_we_o}), 64'(0));
        chk("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'(0));
        chk("rst_sel_data", {28'(wb_sel_o), mem_resp_data_o}, 64'(0));
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            smem[32'h100 + 32'(4*i)] = 32'h11 * (i + 1);
            mref[32'h100 + 32'(4*i)] = 32'h11 * (i + 1);
        end

        do_req(1'b0, 32'h0000_0104, 0, 4'hF, 1'b0);          // cold miss
        chk("lit_cold_data", 64'(last_data), 64'h22);
        do_req(1'b0, 32'h0000_0104, 0, 4'hF, 1'b0);          // hit, no bus
        chk("lit_hit_data", 64'(last_data), 64'h22);
        chk("lit_hit_nobus", 64'(act_log.size()), 64'(0));
        do_req(1'b1, 32'h0000_0108, 32'hAABBCCDD, 4'b0011, 1'b0);
        if (act_log.size() > 0) chk("lit_store_sel", 64'(act_log[0].sel), 64'h3);
        do_req(1'b0, 32'h0000_0108, 0, 4'hF, 1'b0);          // merged hit
        chk("lit_merge_data", 64'(last_data), 64'h0000CCDD);
        do_req(1'b0, 32'h0000_0504, 0, 4'hF, 1'b0);          // evict
        do_req(1'b0, 32'h0000_0104, 0, 4'hF, 1'b0);          // refill again
        chk("lit_evict_beats", 64'(act_log.size()), 64'(4));
        do_req(1'b0, 32'hA000_0000, 0, 4'hF, 1'b0);          // uncached
        do_req(1'b0, 32'hA000_0000, 0, 4'hF, 1'b0);
        chk("lit_unc_again", 64'(act_log.size()), 64'(1));
        do_req(1'b1, 32'hA000_0010, 32'h1234_5678, 4'b1100, 1'b0);
        do_req(1'b0, 32'hA000_0010, 0, 4'b0100, 1'b0);
        rty_at = 2;
        do_req(1'b0, 32'h0000_0334, 0, 4'hF, 1'b0);          // retry on beat 2
        if (act_log.size() > 3) chk("lit_rty_reissue", 64'(act_log[3].adr), 64'h338);
        do_req(1'b0, 32'h0000_0334, 0, 4'hF, 1'b0);
        err_at = 1;
        do_req(1'b0, 32'h0000_0444, 0, 4'hF, 1'b0);          // error on beat 1
        chk("lit_err_flag", {32'(last_err), last_data}, {32'h1, 32'h0});
        do_req(1'b0, 32'h0000_0444, 0, 4'hF, 1'b0);          // must miss
        chk("lit_err_then_miss", 64'(act_log.size()), 64'(4));
        do_req(1'b1, 32'h0000_0658, 32'hDEAD_BEEF, 4'hF, 1'b0); // no allocate
        do_req(1'b0, 32'h0000_0658, 0, 4'hF, 1'b0);
        chk("lit_noalloc_data", 64'(last_data), 64'hDEAD_BEEF);
        do_req(1'b0, 32'h0000_0104, 0, 4'hF, 1'b0);          // hit
        flush_i = 1'b1; @(negedge clk); flush_i = 1'b0; model_reset();
        chk("flush_no_cyc", 64'(wb_cyc_o), 64'(0));
        do_req(1'b0, 32'h0000_0104, 0, 4'hF, 1'b0);          // miss after flush
        do_req(1'b0, 32'h0000_0104, 0, 4'hF, 1'b1);          // flush + request together

        // reset in the middle of a refill
        act_log.delete(); scnt = 0;
        mem_req_we_i = 1'b0; mem_req_addr_i = 32'h0000_0204; mem_req_be_i = 4'hF;
        mem_req_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrefill_cyc", 64'(wb_cyc_o), 64'(1));
        rst = 1'b1; #1;
        chk("rst_async_drop", 64'({wb_cyc_o, wb_stb_o, mem_req_ready_o}), 64'(0));
        @(negedge clk);
        chk("rst_outputs", {wb_adr_o, 24'(wb_sel_o), 3'(0), wb_we_o, mem_resp_err_o, 3'(0)}, 64'(0));
        mem_req_valid_i = 1'b0; rst = 1'b0; model_reset();
        @(negedge clk);
        do_req(1'b0, 32'h0000_0104, 0, 4'hF, 1'b0);          // miss after reset
        do_req(1'b0, 32'h0000_0204, 0, 4'hF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dcache_wt.md
DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 Parameter NUM_LINES, default 16, number of direct-mapped lines; power of 2, at least 2.
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per line; power of 2, at least 1.
REQ-003 Parameter UNCACHED_TOP, default 4'hA, value of addr[31:28] that marks an uncached access.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 mem_req_addr_i  in  32  byte address, word aligned.
REQ-008 mem_req_wdata_i  in  32  store data.
REQ-009 mem_req_we_i  in  1  1 = store, 0 = load.
REQ-010 mem_req_be_i  in  4  byte enables.
REQ-011 mem_req_valid_i  in  1  request; held high with stable fields until ready.
REQ-012 flush_i  in  1  invalidate all lines.
REQ-013 mem_resp_data_o  out  32  load data, valid while ready is high.
REQ-014 mem_req_ready_o  out  1  one-cycle completion pulse.
REQ-015 mem_resp_err_o  out  1  bus error flag, valid while ready is high.
REQ-016 wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o/wb_stb_o/wb_cyc_o  out  32/32/1/4/1/1  Wishbone master outputs.
REQ-017 wb_dat_i/wb_ack_i/wb_rty_i/wb_err_i  in  32/1/1/1  Wishbone master inputs.

Function
REQ-018 Address split: offset = addr[1:0] (ignored); word = next log2(LINE_WORDS) bits; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
REQ-019 Storage: per-line valid bit and tag, plus data array; direct-mapped, write-through, no-write-allocate.
REQ-020 FSM states: IDLE, REFILL, WRITE, UNC_RD, DONE.
REQ-021 IDLE, flush_i high: clear all valid bits in one cycle; stay in IDLE; flush has priority over a pending request, which is serviced on the next cycle.
REQ-022 IDLE, load, cached address, hit (valid and tag equal): go to DONE with the cached word registered; ready 1 cycle after the request is sampled.
REQ-023 IDLE, load, cached address, miss: go to REFILL; clear the line's valid bit.
REQ-024 REFILL: cyc=1 and stb=1 held; we=0; sel=4'hF.
REQ-025 REFILL addresses: {tag, index, beat, 2'b00}, beat 0..LINE_WORDS-1.
REQ-026 REFILL per beat: each ack writes wb_dat_i into the data array and increments beat; the requested word is captured when beat equals the request word index.
REQ-027 REFILL completion: on the last ack, set valid, write the tag, go to DONE.
REQ-028 IDLE, store (cached or uncached): go to WRITE.
REQ-029 WRITE bus cycle: single beat with adr=addr, dat=wdata, sel=be, we=1.
REQ-030 WRITE on ack: if cached and hit, merge the enabled bytes into the cached word; go to DONE.
REQ-031 IDLE, load, uncached address: go to UNC_RD; single-beat read with sel=be; no array update; on ack, register the data and go to DONE.
REQ-032 wb_rty_i on any beat: drop stb for one cycle, then reissue the same beat; beat count is unchanged.
REQ-033 wb_err_i: end the bus cycle (cyc=0), leave the line invalid, go to DONE with mem_resp_err_o=1 and data 0.
REQ-034 DONE: ready=1 for exactly one cycle, then return to IDLE; valid is ignored in DONE, so no request is serviced twice.
REQ-035 Wishbone outputs are registered; cyc and stb are 0 in IDLE and DONE.
REQ-036 Worst-case load-miss latency without stalls: LINE_WORDS + 2 cycles.

Reset
REQ-037 rst high at any time, including mid-REFILL: state to IDLE, all valid bits to 0, beat to 0.
REQ-038 Outputs under reset: ready, err, cyc, stb, we all 0; adr, dat, sel, resp_data all 0.
REQ-039 The data and tag arrays need no reset.

Verification (NUM_LINES=16, LINE_WORDS=4)
REQ-040 Cold load at 0x0000_0104: 4 reads at 0x100..0x10C returning 0x11,0x22,0x33,0x44 -> ready with data 0x22; a repeat load gives ready after 1 cycle, data 0x22, no cyc.
REQ-041 After REQ-040, store 0xAABBCCDD to 0x108 with be=4'b0011 -> bus write sel=0011; then load 0x108 hits and returns 0x0000CCDD.
REQ-042 Load at 0x0000_0504 (same index, different tag) evicts the line; a later load of 0x104 misses and refills again.
REQ-043 Load at 0xA000_0000 -> single bus read, no refill; repeat load goes to the bus again.
REQ-044 rty on beat 2 of a refill -> beat 2 reissued, final data correct; err on beat 1 -> ready with err=1 and data 0, and the next load to the same line misses.
REQ-045 Reset asserted mid-refill, or flush_i after a fill -> cyc drops and the next load to that line misses.
